// File: rtl/port_debounce_pkg.sv
// Shared state encoding and helpers for the key debouncer.
// Purely declarative: no timing or flow-control behaviour.
package port_debounce_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

endpackage

// File: rtl/port_debounce_sync_ff.sv
// Parameter-width two-flop synchronizer for asynchronous board inputs.
// Latency 2 cycles; no backpressure, samples every cycle.
module sync_ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/port_debounce.sv
// Debounces the active-low write key, emits a clean level, a press strobe and a frozen switch byte.
// Latency DEBOUNCE_CYCLES+3 cycles on press and on release; no backpressure.
module port_debounce
   import port_debounce_pkg::*;
#(
   parameter  int WIDTH           = 8,
   parameter  int DEBOUNCE_CYCLES = 500000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_n,
   input  logic [WIDTH-1:0] sw,
   output logic             port_write,
   output logic             port_strobe,
   output logic [WIDTH-1:0] port_in
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             key_raw;
   logic             key_s;
   logic [WIDTH-1:0] sw_s;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   assign key_raw = ~key_n;

   sync_ff #(.W(1)) u_key_sync (
      .clk   (clk),
      .reset (reset),
      .d     (key_raw),
      .q     (key_s)
   );

   sync_ff #(.W(WIDTH)) u_sw_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sw),
      .q     (sw_s)
   );

   // port_write is updated on the same edge as the state it decodes, so it
   // tracks PRESSED/RELEASE_WAIT with no extra cycle of lag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         port_write  <= 1'b0;
         port_strobe <= 1'b0;
         port_in     <= '0;
      end else begin
         port_strobe <= 1'b0;
         case (state)
            IDLE: begin
               if (key_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!key_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state       <= PRESSED;
                  cnt         <= '0;
                  port_write  <= 1'b1;
                  port_strobe <= 1'b1;
                  port_in     <= sw_s;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!key_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               // A bounce back to pressed resumes the press without a new strobe.
               if (key_s) begin
                  state <= PRESSED;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state      <= IDLE;
                  cnt        <= '0;
                  port_write <= 1'b0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               cnt        <= '0;
               port_write <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_port_debounce.sv
// Directed bench for port_debounce with DEBOUNCE_CYCLES=4: vector table plus reset sequences.
module tb_port_debounce;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_n;
   logic [7:0] sw;
   logic       port_write;
   logic       port_strobe;
   logic [7:0] port_in;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       key_n;
      logic [7:0] sw;
      logic       w;
      logic       s;
      logic [7:0] in_v;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   port_debounce #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_n       (key_n),
      .sw          (sw),
      .port_write  (port_write),
      .port_strobe (port_strobe),
      .port_in     (port_in)
   );

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic k, input logic [7:0] s, input logic w,
                      input logic st, input logic [7:0] pin);
      vec_t v;
      v.key_n = k;
      v.sw    = s;
      v.w     = w;
      v.s     = st;
      v.in_v  = pin;
      vecs.push_back(v);
   endtask

   // Inputs change at the falling edge; outputs are read at the next falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic w, input logic st, input logic [7:0] pin);
      chk1({tag, "_write"}, port_write, w);
      chk1({tag, "_strobe"}, port_strobe, st);
      chk8({tag, "_in"}, port_in, pin);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;

      // Key held and switches set through reset: nothing may leak out.
      reset = 1'b1;
      key_n = 1'b0;
      sw    = 8'hA5;
      @(negedge clk);
      chk_out("reset_early", 1'b0, 1'b0, 8'h00);
      repeat (9) step();
      chk_out("reset_end", 1'b0, 1'b0, 8'h00);

      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk_out($sformatf("rst_hold_c%0d", k), k == 7, k == 7, (k == 7) ? 8'hA5 : 8'h00);
      end
      key_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         chk_out($sformatf("rst_rel_c%0d", k), k < 7, 1'b0, 8'hA5);
      end

      // Clean press of 20 cycles with sw=3C.
      for (int k = 1; k <= 20; k++) add(1'b0, 8'h3C, k >= 7, k == 7, (k >= 7) ? 8'h3C : 8'hA5);
      for (int k = 21; k <= 30; k++) add(1'b1, 8'h3C, k <= 26, 1'b0, 8'h3C);
      // Press bounce: low 3, high 1, low 3, then high.
      for (int k = 1; k <= 15; k++) add(!(k <= 3 || (k >= 5 && k <= 7)), 8'h77, 1'b0, 1'b0, 8'h3C);
      // Press with sw=11, switches move to FF mid-press, then release bounce.
      for (int k = 1; k <= 10; k++)
         add(1'b0, (k >= 8) ? 8'hFF : 8'h11, k >= 7, k == 7, (k >= 7) ? 8'h11 : 8'h3C);
      for (int k = 11; k <= 24; k++) add(!(k == 13 || k == 14), 8'hFF, k <= 20, 1'b0, 8'h11);
      // Next press captures the new switch value.
      for (int k = 1; k <= 16; k++)
         add(k > 8, 8'hFF, k >= 7 && k <= 14, k == 7, (k >= 7) ? 8'hFF : 8'h11);

      foreach (vecs[i]) begin
         key_n = vecs[i].key_n;
         sw    = vecs[i].sw;
         step();
         chk_out($sformatf("vec%0d", i), vecs[i].w, vecs[i].s, vecs[i].in_v);
      end

      // Reset two cycles after a strobe while the key is still held.
      key_n = 1'b0;
      sw    = 8'h5A;
      n     = 0;
      while (!port_strobe && n < 20) begin
         step();
         n++;
      end
      chk8("midrst_latency", 8'(n), 8'd7);
      chk8("midrst_in_before", port_in, 8'h5A);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk_out("midrst_async", 1'b0, 1'b0, 8'h00);
      repeat (3) step();
      reset = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         step();
         chk_out($sformatf("midrst_c%0d", k), k == 7, k == 7, (k == 7) ? 8'h5A : 8'h00);
      end
      step();
      chk_out("midrst_after", 1'b1, 1'b0, 8'h5A);
      key_n = 1'b1;
      repeat (8) step();
      chk_out("final_idle", 1'b0, 1'b0, 8'h5A);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
